// File: rtl/mul_seq_ctrl.sv
// Sequential wide unsigned multiplier controller: walks operand digit pairs through a
// shared external 4x4 multiplier and shift-accumulates the partial products.
module mul_seq_ctrl #(
  parameter int unsigned N_DIGITS = 2,
  localparam int unsigned W = 4 * N_DIGITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [3:0]     MulA,
  output logic [3:0]     MulB,
  input  logic [7:0]     MulP,
  output logic           Busy,
  output logic           Done,
  output logic [2*W-1:0] Product
);

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [W-1:0]   a_lat, b_lat;
  logic [2*W-1:0] acc, acc_next, pp;
  logic [IW-1:0]  i, j;
  logic           accept, last_pair;
  int unsigned    sh;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_pair  = (i == LAST) && (j == LAST);
    MulA       = '0;
    MulB       = '0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        Busy = 1'b1;
        MulA = a_lat[4*i +: 4];
        MulB = b_lat[4*j +: 4];
        if (last_pair) state_next = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept     = 1'b1;
          state_next = S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Partial product weight is 16^(i+j); zero-filled shift, truncated to the accumulator width.
  always_comb begin
    sh       = 4 * (32'(i) + 32'(j));
    pp       = (2*W)'(MulP) << sh;
    acc_next = acc + pp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat   <= '0;
      b_lat   <= '0;
      acc     <= '0;
      Product <= '0;
      i       <= '0;
      j       <= '0;
    end else if (accept) begin
      a_lat <= A;
      b_lat <= B;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_next;
      if (j == LAST) begin
        j <= '0;
        i <= i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
      if (last_pair) Product <= acc_next;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl (N_DIGITS=2) with a behavioural 4x4 multiplier on MulP.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [7:0]  A, B;
  logic [3:0]  MulA, MulB;
  logic [7:0]  MulP;
  logic        Busy, Done;
  logic [15:0] Product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_prod;

  mul_seq_ctrl #(.N_DIGITS(2)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B),
    .MulA(MulA), .MulB(MulB), .MulP(MulP),
    .Busy(Busy), .Done(Done), .Product(Product)
  );

  assign MulP = {4'b0, MulA} * {4'b0, MulB};

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [31:0] seq;  // {MulA,MulB} for the four CALC cycles, first pair in the top byte
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    logic [31:0] s;
    s = vecs[idx].seq;
    A = vecs[idx].a;
    B = vecs[idx].b;
    Start = 1'b1;
    step();
    Start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    chk("calc_product_held", 32'(Product), 32'(last_prod));
    for (int c = 0; c < 4; c++) begin
      chk("calc_busy_done", {30'b0, Busy, Done}, 32'b10);
      chk("calc_digits", {24'b0, MulA, MulB}, {24'b0, s[31-8*c -: 8]});
      step();
    end
    chk("done_flags", {30'b0, Busy, Done}, 32'b01);
    chk("done_digits", {24'b0, MulA, MulB}, 32'b0);
    chk("done_product", 32'(Product), 32'(vecs[idx].prod));
    last_prod = vecs[idx].prod;
    step();
    chk("idle_flags", {30'b0, Busy, Done}, 32'b00);
    chk("idle_product", 32'(Product), 32'(last_prod));
  endtask

  initial begin
    vecs[0] = '{a: 8'hFF, b: 8'hFF, prod: 16'hFE01, seq: 32'hFFFFFFFF};
    vecs[1] = '{a: 8'hA5, b: 8'h3C, prod: 16'h26AC, seq: 32'h5C53ACA3};
    vecs[2] = '{a: 8'h00, b: 8'h7B, prod: 16'h0000, seq: 32'h0B070B07};
    vecs[3] = '{a: 8'h01, b: 8'h01, prod: 16'h0001, seq: 32'h11100100};
    vecs[4] = '{a: 8'h12, b: 8'h34, prod: 16'h03A8, seq: 32'h24231413};
    vecs[5] = '{a: 8'h80, b: 8'h02, prod: 16'h0100, seq: 32'h02008280};

    rst = 1'b1; Start = 1'b0; A = 8'h5A; B = 8'hA5;
    step(); step();
    rst = 1'b0;
    chk("reset_flags", {30'b0, Busy, Done}, 32'b00);
    chk("reset_product", 32'(Product), 32'h0);
    chk("reset_digits", {24'b0, MulA, MulB}, 32'h0);
    last_prod = 16'h0;
    step();
    chk("idle_no_start", {30'b0, Busy, Done}, 32'b00);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Start pulsed mid-CALC must be ignored
    A = 8'hFF; B = 8'hFF; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    A = 8'h11; B = 8'h11; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("ign_digits", {24'b0, MulA, MulB}, 32'hFF);
    step(); step();
    chk("ign_done", {30'b0, Busy, Done}, 32'b01);
    chk("ign_product", 32'(Product), 32'hFE01);
    step();
    chk("ign_no_restart", {30'b0, Busy, Done}, 32'b00);
    last_prod = 16'hFE01;

    // Reset in the second CALC cycle discards the partial result
    A = 8'h12; B = 8'h34; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    chk("mid_busy", {31'b0, Busy}, 32'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_flags", {30'b0, Busy, Done}, 32'b00);
    chk("rst_product", 32'(Product), 32'h0);
    chk("rst_digits", {24'b0, MulA, MulB}, 32'h0);
    last_prod = 16'h0;
    step();
    chk("rst_stays_idle", {30'b0, Busy, Done}, 32'b00);
    run_vec(1);

    // Start held high: back-to-back products, Done every 5 cycles
    A = vecs[1].a; B = vecs[1].b; Start = 1'b1;
    step();
    for (int p = 1; p <= 3; p++) begin
      if (p < 3) begin
        A = vecs[p+1].a;
        B = vecs[p+1].b;
      end else begin
        Start = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        chk("strm_busy", {30'b0, Busy, Done}, 32'b10);
        step();
      end
      chk("strm_done", {30'b0, Busy, Done}, 32'b01);
      chk("strm_product", 32'(Product), 32'(vecs[p].prod));
      step();
      if (p < 3) chk("strm_restart", {30'b0, Busy, Done}, 32'b10);
      else       chk("strm_end_idle", {30'b0, Busy, Done}, 32'b00);
    end
    chk("strm_product_held", 32'(Product), 32'(vecs[3].prod));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
